digit_timer_ctrl: RTL and testbench

//  Sequencer for the BCD-digits-to-cycle-count datapath behind the timer device.
//  - Captures three BCD digits (d1, d2, d3) on a start request.
//  - Forms the cycle count from them with one shift-add multiply-accumulate per clock.
//  - Counts that value down to zero, then raises a done pulse and a sticky irq.
//  - Sits between the switch/MMIO device registers and the CPU interrupt line.

---
 rtl/digit_timer_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_digit_timer_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_timer_ctrl.sv
// Purpose : sequences three BCD digits into a cycle count (one shift-add MAC per clock), counts it down, then flags done/irq.
// Latency : start accepted in cycle T -> CALC T+1..T+3 -> RUN from T+4 with remain=N -> done pulse in T+4+N (pause low).
// Backpressure: none; start is ignored while busy, pause freezes the countdown in RUN, stop aborts from any state.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   start, stop, pause    control requests (start sampled only in IDLE, pause is a level)
//   d1, d2, d3            BCD digits weighted by W1, W2, W3
//   irq_ack               clears the sticky irq flag
//   busy                  high while in CALC or RUN
//   remain                cycles left in RUN; running accumulator in CALC
//   done                  one-cycle completion pulse
//   irq, err              sticky completion flag and sticky bad-digit flag
module digit_timer_ctrl #(
    parameter int               CNT_W = 30,
    parameter logic [CNT_W-1:0] W1    = CNT_W'(100_000_000),
    parameter logic [CNT_W-1:0] W2    = CNT_W'(10_000_000),
    parameter logic [CNT_W-1:0] W3    = CNT_W'(1_000_000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [3:0]       d1,
    input  logic [3:0]       d2,
    input  logic [3:0]       d3,
    input  logic             irq_ack,
    output logic             busy,
    output logic [CNT_W-1:0] remain,
    output logic             done,
    output logic             irq,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         step_q, step_d;
    logic [3:0]         d1_q, d1_d;
    logic [3:0]         d2_q, d2_d;
    logic [3:0]         d3_q, d3_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic               done_q, done_d;
    logic               irq_q, irq_d;
    logic               err_q, err_d;

    logic               irq_set;
    logic               digits_ok;
    logic [CNT_W-1:0]   prod1, prod2, prod3;
    logic [CNT_W-1:0]   term;
    logic [CNT_W-1:0]   acc_next;

    // Digit times a constant weight as a sum of shifted copies of the weight;
    // with a constant weight each shift is just wiring.
    function automatic logic [CNT_W-1:0] shift_add(input logic [3:0] dig,
                                                   input logic [CNT_W-1:0] wgt);
        logic [CNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            if (dig[i]) begin
                sum = sum + (wgt << i);
            end
        end
        return sum;
    endfunction

    assign digits_ok = (d1 <= 4'd9) && (d2 <= 4'd9) && (d3 <= 4'd9);

    // Largest sum is 9*(W1+W2+W3) = 999,000,000 which fits in 30 bits.
    always_comb begin
        prod1 = shift_add(d1_q, W1);
        prod2 = shift_add(d2_q, W2);
        prod3 = shift_add(d3_q, W3);
        case (step_q)
            2'd0:    term = prod1;
            2'd1:    term = prod2;
            default: term = prod3;
        endcase
        acc_next = remain_q + term;
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        d3_d     = d3_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        irq_set  = 1'b0;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                // stop beats start; a rejected start leaves the latches untouched
                if (start && !stop) begin
                    if (digits_ok) begin
                        d1_d     = d1;
                        d2_d     = d2;
                        d3_d     = d3;
                        remain_d = '0;
                        step_d   = 2'd0;
                        err_d    = 1'b0;
                        state_d  = ST_CALC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_CALC: begin
                if (stop) begin
                    state_d  = ST_IDLE;
                    remain_d = '0;
                    step_d   = 2'd0;
                end else if (step_q == 2'd2) begin
                    step_d = 2'd0;
                    if (acc_next != '0) begin
                        remain_d = acc_next;
                        state_d  = ST_RUN;
                    end else begin
                        // zero-length timer completes straight out of CALC
                        remain_d = '0;
                        state_d  = ST_IDLE;
                        done_d   = 1'b1;
                        irq_set  = 1'b1;
                    end
                end else begin
                    remain_d = acc_next;
                    step_d   = step_q + 2'd1;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d  = ST_IDLE;
                    remain_d = '0;
                end else if (!pause) begin
                    if (remain_q == CNT_W'(1)) begin
                        remain_d = '0;
                        state_d  = ST_IDLE;
                        done_d   = 1'b1;
                        irq_set  = 1'b1;
                    end else begin
                        remain_d = remain_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                remain_d = '0;
                step_d   = 2'd0;
            end
        endcase

        // a completion in the same cycle as an ack keeps irq set
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            step_q   <= 2'd0;
            d1_q     <= 4'd0;
            d2_q     <= 4'd0;
            d3_q     <= 4'd0;
            remain_q <= '0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            d3_q     <= d3_d;
            remain_q <= remain_d;
            done_q   <= done_d;
            irq_q    <= irq_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q == ST_CALC) || (state_q == ST_RUN);
    assign remain = remain_q;
    assign done   = done_q;
    assign irq    = irq_q;
    assign err    = err_q;

endmodule

// File: tb/tb_digit_timer_ctrl.sv
module tb_digit_timer_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start, stop, pause, irq_ack;
    logic [3:0]  d1, d2, d3;
    logic        busy, done, irq, err;
    logic [29:0] remain;

    // second instance with the default (large) weights, own control inputs
    logic        b_start, b_stop, b_pause, b_irq_ack;
    logic [3:0]  b_d1, b_d2, b_d3;
    logic        b_busy, b_done, b_irq, b_err;
    logic [29:0] b_remain;

    int total = 0;
    int bad   = 0;

    digit_timer_ctrl #(.CNT_W(30), .W1(30'd100), .W2(30'd10), .W3(30'd1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .d1(d1), .d2(d2), .d3(d3), .irq_ack(irq_ack),
        .busy(busy), .remain(remain), .done(done), .irq(irq), .err(err)
    );

    digit_timer_ctrl dut_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop), .pause(b_pause),
        .d1(b_d1), .d2(b_d2), .d3(b_d3), .irq_ack(b_irq_ack),
        .busy(b_busy), .remain(b_remain), .done(b_done), .irq(b_irq), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start, stop, pause, ack;
        logic [3:0]  d1, d2, d3;
        logic        busy;
        logic [29:0] remain;
        logic        done, irq, err;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; pause = 0; irq_ack = 0;
        d1 = 0; d2 = 0; d3 = 0;
    endtask

    // start request in cycle T, returns in cycle T+4
    task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        start = 1; d1 = a; d2 = b; d3 = c;
        tick();
        start = 0;
        tick(); tick(); tick();
    endtask

    int n;
    int k;

    initial begin
        rst_n = 0;
        idle_inputs();
        b_start = 0; b_stop = 0; b_pause = 0; b_irq_ack = 0;
        b_d1 = 0; b_d2 = 0; b_d3 = 0;

        //                start stop pause ack  d1    d2    d3    busy remain done irq err
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b1, 30'd0,  1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 30'd0,  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 30'd0,  1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 30'd3,  1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 30'd2,  1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 30'd2,  1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 30'd1,  1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 30'd0,  1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 30'd0,  1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 30'd0,  1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'hA, 4'd0, 1'b0, 30'd0,  1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 30'd0,  1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2, 1'b1, 30'd0,  1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd9, 4'd9, 1'b1, 30'd0,  1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 30'd10, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 30'd12, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 30'd0,  1'b0, 1'b0, 1'b0};

        // reset state
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_remain", 32'(remain), 0);
        check("rst_done", 32'(done), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // per-cycle vector table
        foreach (vecs[i]) begin
            start = vecs[i].start; stop = vecs[i].stop; pause = vecs[i].pause;
            irq_ack = vecs[i].ack; d1 = vecs[i].d1; d2 = vecs[i].d2; d3 = vecs[i].d3;
            tick();
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_remain", i), 32'(remain), 32'(vecs[i].remain));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].irq));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
        end
        idle_inputs();
        tick();

        // zero digits: three CALC cycles then done, RUN never entered
        start = 1;
        tick();
        start = 0;
        check("zero_busy1", 32'(busy), 1);
        tick();
        tick();
        check("zero_busy3", 32'(busy), 1);
        check("zero_remain3", 32'(remain), 0);
        tick();
        check("zero_done", 32'(done), 1);
        check("zero_busy_end", 32'(busy), 0);
        check("zero_irq", 32'(irq), 1);
        tick();
        check("zero_done_pulse", 32'(done), 0);

        // 1,2,3: remain 123 at T+4, done at T+127
        launch(4'd1, 4'd2, 4'd3);
        check("c1_remain_t4", 32'(remain), 123);
        check("c1_busy_t4", 32'(busy), 1);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("c1_done_cycle", 32'(n), 123);
        check("c1_irq", 32'(irq), 1);
        check("c1_busy_end", 32'(busy), 0);
        tick();

        // pause 10 cycles mid-RUN: done moves to T+137
        launch(4'd1, 4'd2, 4'd3);
        for (int i = 0; i < 20; i++) tick();
        check("c4_remain_pre", 32'(remain), 103);
        pause = 1;
        for (int i = 0; i < 10; i++) tick();
        check("c4_remain_frozen", 32'(remain), 103);
        check("c4_busy_frozen", 32'(busy), 1);
        pause = 0;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("c4_done_cycle", 32'(n + 30), 133);
        tick();

        // stop at remain=50
        launch(4'd1, 4'd2, 4'd3);
        k = 0;
        while (remain !== 30'd50 && k < 300) begin
            tick();
            k++;
        end
        check("c5_reach50", 32'(remain), 50);
        stop = 1;
        tick();
        stop = 0;
        check("c5_busy", 32'(busy), 0);
        check("c5_remain", 32'(remain), 0);
        check("c5_done", 32'(done), 0);
        check("c5_irq", 32'(irq), 1);
        tick();
        check("c5_done_later", 32'(done), 0);

        // asynchronous reset mid-CALC
        start = 1; d1 = 4'd1; d2 = 4'd2; d3 = 4'd3;
        tick();
        start = 0;
        tick();
        check("c8_pre_remain", 32'(remain), 100);
        #2 rst_n = 0;
        #1;
        check("c8_busy", 32'(busy), 0);
        check("c8_remain", 32'(remain), 0);
        check("c8_done", 32'(done), 0);
        check("c8_irq", 32'(irq), 0);
        check("c8_err", 32'(err), 0);
        tick();
        rst_n = 1;
        tick();
        check("c8_stay_idle", 32'(busy), 0);

        // irq_ack coinciding with the completion edge, then a clearing ack
        launch(4'd0, 4'd0, 4'd5);
        check("c7_remain_t4", 32'(remain), 5);
        k = 0;
        while (remain !== 30'd1 && k < 20) begin
            tick();
            k++;
        end
        check("c7_reach1", 32'(remain), 1);
        irq_ack = 1;
        tick();
        irq_ack = 0;
        check("c7_done", 32'(done), 1);
        check("c7_irq_set_wins", 32'(irq), 1);
        irq_ack = 1;
        tick();
        irq_ack = 0;
        check("c7_irq_cleared", 32'(irq), 0);

        // default weights 9,9,9
        b_start = 1; b_d1 = 4'd9; b_d2 = 4'd9; b_d3 = 4'd9;
        tick();
        b_start = 0;
        tick();
        check("c6_step0", 32'(b_remain), 900_000_000);
        tick();
        check("c6_step1", 32'(b_remain), 990_000_000);
        tick();
        check("c6_remain_t4", 32'(b_remain), 999_000_000);
        check("c6_busy", 32'(b_busy), 1);
        tick();
        check("c6_dec", 32'(b_remain), 998_999_999);
        b_stop = 1;
        tick();
        b_stop = 0;
        check("c6_stop_remain", 32'(b_remain), 0);
        check("c6_stop_busy", 32'(b_busy), 0);
        check("c6_irq", 32'(b_irq), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
